// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned/two's-complement subtractor. On an accepted start the
// operands are captured into shift registers, and one difference bit is then
// resolved per clock, LSB first, through a single borrow flip-flop. After
// WIDTH bit-steps the full result and its flags are published together and
// done pulses for one cycle.
//
// Timing (start accepted at edge E0):
//   E1 .. E(WIDTH)   one bit processed per edge; E(WIDTH) loads the outputs
//   E(WIDTH)-E(WIDTH+1)  done = 1
//   E(WIDTH+1)       back to IDLE; a held start is accepted one edge later
//
// Ports:
//   clk     in   1      rising-edge clock for all state
//   rst     in   1      asynchronous active-high reset
//   start   in   1      begin a subtraction (sampled only in IDLE)
//   a       in   WIDTH  minuend, captured on the accepting edge
//   b       in   WIDTH  subtrahend, captured on the accepting edge
//   busy    out  1      high while in RUN or DONE
//   done    out  1      one-cycle pulse, result and flags valid
//   diff    out  WIDTH  registered a - b modulo 2^WIDTH
//   borrow  out  1      final borrow-out (a < b unsigned)
//   zero    out  1      diff == 0
//   neg     out  1      diff[WIDTH-1]
//   ovf     out  1      signed overflow of a - b
// -----------------------------------------------------------------------------
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             zero,
   output logic             neg,
   output logic             ovf
);

   // Counter only needs to reach WIDTH-1; the step after that leaves RUN.
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   // Operand shift registers (consumed from bit 0) and the result
   // accumulator (filled from the top so it is LSB-aligned after WIDTH steps).
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic             bin;
   logic [CW-1:0]    cnt;

   // Single-bit full subtractor on the current LSBs.
   logic             a_bit;
   logic             b_bit;
   logic             d_bit;
   logic             bout;
   logic             last_bit;
   logic [WIDTH-1:0] res_final;

   assign a_bit     = a_sr[0];
   assign b_bit     = b_sr[0];
   assign d_bit     = a_bit ^ b_bit ^ bin;
   assign bout      = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bin);
   assign last_bit  = (cnt == CW'(WIDTH - 1));
   // Value res_sr takes on this edge; on the last step it is the full result.
   assign res_final = {d_bit, res_sr[WIDTH-1:1]};

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking (<=) so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   // NOTE: the default assignment first guarantees state_nxt is written on
   // every path, so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last_bit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;   // start is ignored here: no restart
         default: state_nxt = IDLE;
      endcase
   end

   // busy/done decode straight from the state register, so reset clears
   // them at once and done is exactly one cycle wide.
   assign busy = (state != IDLE);
   assign done = (state == DONE);

   // ------------------------------------------------------------------
   // Datapath: operand capture, bit-serial step, result publication
   // ------------------------------------------------------------------
   // NOTE: the shift registers are deliberately reset here; a reset in
   // mid-operation must leave no operand or partial result behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         bin    <= 1'b0;
         cnt    <= '0;
         diff   <= '0;
         borrow <= 1'b0;
         zero   <= 1'b0;
         neg    <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr   <= a;
                  b_sr   <= b;
                  res_sr <= '0;
                  bin    <= 1'b0;   // no carry-in: first borrow is always 0
                  cnt    <= '0;
               end
            end

            RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= res_final;
               bin    <= bout;
               cnt    <= cnt + CW'(1);
               // Only the final step touches the visible outputs, so the
               // partially built result never shows on diff.
               if (last_bit) begin
                  diff   <= res_final;
                  borrow <= bout;
                  zero   <= (res_final == '0);
                  neg    <= d_bit;
                  // On the last step a_bit/b_bit are the operand MSBs.
                  ovf    <= (a_bit ^ b_bit) & (a_bit ^ d_bit);
               end
            end

            default: begin
               // DONE: outputs hold until the next result.
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Directed bench for serial_subtractor (WIDTH = 8). Inputs change on the
// falling edge; outputs are sampled on the falling edge (or shortly after an
// asynchronous reset), away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow;
   logic         zero;
   logic         neg;
   logic         ovf;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] last_diff;   // result the bench expects diff to be holding
   logic [W-1:0] pa [0:15];
   logic [W-1:0] pb [0:15];
   logic [W+3:0] ref_val;
   int           done_seen;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow),
      .zero   (zero),
      .neg    (neg),
      .ovf    (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: {diff, borrow, zero, neg, ovf} for a - b.
   function automatic logic [W+3:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0] d;
      d = x - y;
      return {d, (x < y), (d == '0), d[W-1], (x[W-1] ^ y[W-1]) & (x[W-1] ^ d[W-1])};
   endfunction

   // One full operation with start pulsed for a single edge. ef = {borrow,zero,neg,ovf}.
   task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ed, input logic [3:0] ef);
      @(negedge clk);
      a = av; b = bv; start = 1'b1;
      @(posedge clk);                         // E0: accept
      @(negedge clk);
      start = 1'b0;
      a = ~av; b = av ^ 8'h5C;                // late operand changes must not matter
      check({tag, "_busy_run"}, busy, 1);
      for (int i = 1; i < W; i++) begin
         @(posedge clk);
         @(negedge clk);
         check({tag, "_done_early"}, done, 0);
         check({tag, "_diff_hold"}, diff, last_diff);
      end
      @(posedge clk);                         // E(W)
      @(negedge clk);
      check({tag, "_done"}, done, 1);
      check({tag, "_diff"}, diff, ed);
      check({tag, "_flags"}, {borrow, zero, neg, ovf}, ef);
      @(posedge clk);                         // E(W+1)
      @(negedge clk);
      check({tag, "_done_drop"}, done, 0);
      check({tag, "_idle"}, busy, 0);
      last_diff = ed;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      last_diff = '0;

      // ---- reset state ----
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_diff", diff, 0);
      check("rst_flags", {borrow, zero, neg, ovf}, 4'b0000);
      rst = 1'b0;

      // ---- directed vectors ----
      do_op("v35_12", 8'h35, 8'h12, 8'h23, 4'b0000);
      do_op("v10_20", 8'h10, 8'h20, 8'hF0, 4'b1010);
      do_op("v80_01", 8'h80, 8'h01, 8'h7F, 4'b0001);
      do_op("v7f_ff", 8'h7F, 8'hFF, 8'h80, 4'b1011);
      do_op("v5a_5a", 8'h5A, 8'h5A, 8'h00, 4'b0100);

      // ---- start pulsed during RUN is ignored ----
      @(negedge clk);
      a = 8'h35; b = 8'h12; start = 1'b1;
      @(posedge clk);                         // E0
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(posedge clk);              // E1, E2
      @(negedge clk);
      a = 8'h01; b = 8'h02; start = 1'b1;
      @(posedge clk);                         // E3: must be ignored
      @(negedge clk);
      start = 1'b0;
      check("ign_diff_hold", diff, last_diff);
      repeat (5) @(posedge clk);              // E8
      @(negedge clk);
      check("ign_done", done, 1);
      check("ign_diff", diff, 8'h23);
      check("ign_flags", {borrow, zero, neg, ovf}, 4'b0000);
      repeat (2) @(posedge clk);              // E10
      @(negedge clk);
      check("ign_no_restart", busy, 0);
      last_diff = 8'h23;

      // ---- asynchronous reset mid-RUN ----
      @(negedge clk);
      a = 8'h10; b = 8'h20; start = 1'b1;
      @(posedge clk);                         // E0
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);              // E3
      #2 rst = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_diff", diff, 0);
      check("arst_flags", {borrow, zero, neg, ovf}, 4'b0000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done === 1'b1) done_seen++;
      end
      check("arst_no_done", done_seen, 0);
      check("arst_diff_after", diff, 0);
      last_diff = '0;

      // ---- first operation after reset ----
      do_op("post_rst", 8'h10, 8'h20, 8'hF0, 4'b1010);

      // ---- start held high, 16 back-to-back operations ----
      for (int k = 0; k < 16; k++) begin
         pa[k] = 8'($urandom);
         pb[k] = 8'($urandom);
      end
      @(negedge clk);
      a = pa[0]; b = pb[0]; start = 1'b1;
      @(posedge clk);                         // accept op 0
      for (int k = 0; k < 16; k++) begin
         ref_val = model(pa[k], pb[k]);
         for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 1 && k < 15) begin
               a = pa[k+1]; b = pb[k+1];
            end
            if (i == 9 && k == 15) start = 1'b0;
            if (i == 8) begin
               check($sformatf("bb%0d_done", k), done, 1);
               check($sformatf("bb%0d_diff", k), diff, ref_val[W+3:4]);
               check($sformatf("bb%0d_flags", k), {borrow, zero, neg, ovf}, ref_val[3:0]);
            end else begin
               check($sformatf("bb%0d_nodone%0d", k, i), done, 0);
            end
            if (i == 9) check($sformatf("bb%0d_idle", k), busy, 0);
            if (i == 10) check($sformatf("bb%0d_busy", k), busy, (k < 15) ? 1 : 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal values 2 to 32).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-006 Port: a  input  WIDTH  minuend; sampled on the edge that accepts start.
REQ-007 Port: b  input  WIDTH  subtrahend; sampled on the edge that accepts start.
REQ-008 Port: busy  output  1  high while in RUN or DONE.
REQ-009 Port: done  output  1  one-cycle pulse; result and flags are valid.
REQ-010 Port: diff  output  WIDTH  registered result a - b, modulo 2^WIDTH.
REQ-011 Port: borrow  output  1  final borrow-out; 1 iff a < b unsigned.
REQ-012 Port: zero  output  1  1 iff diff == 0.
REQ-013 Port: neg  output  1  diff[WIDTH-1].
REQ-014 Port: ovf  output  1  signed overflow: (a[MSB] ^ b[MSB]) & (a[MSB] ^ diff[MSB]).

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 IDLE with start=1 at an edge:
- latch a and b into shift registers;
- clear the borrow flip-flop and the bit counter;
- go to RUN.
REQ-017 RUN, each edge:
- process one bit, LSB first: d = a_i ^ b_i ^ bin; bout = (~a_i & b_i) | (~(a_i ^ b_i) & bin);
- shift d into the result register and store bout in the borrow flip-flop;
- increment the counter.
REQ-018 After the WIDTH-th RUN edge, the FSM SHALL enter DONE, with diff, borrow, zero, neg and ovf updated on that same edge.
REQ-019 Latency: with start accepted at edge E0, done SHALL be high for exactly the one cycle between edges E(WIDTH) and E(WIDTH+1), then the FSM returns to IDLE.
REQ-020 Result outputs SHALL change only on the edge that enters DONE, and SHALL hold their values until the next result is produced.
REQ-021 Intermediate shift-register contents SHALL NOT appear on diff during RUN.
REQ-022 start SHALL be ignored in RUN and DONE; no queuing and no restart.
REQ-023 With start held high continuously, a new operation SHALL be accepted on the edge following the DONE cycle (IDLE lasts one cycle).
REQ-024 Changes to a or b after acceptance SHALL NOT affect the operation in progress.
REQ-025 The borrow flip-flop SHALL be WIDTH-independent logic; there is no carry-in port, and the initial borrow is always 0.

Reset
REQ-026 When rst is asserted, without waiting for clk, the block SHALL:
- enter IDLE;
- clear busy, done, diff, borrow, zero, neg, ovf, the counter and the shift registers to 0.
REQ-027 A reset asserted mid-RUN SHALL abort the operation, with no done pulse and no partial result visible.
REQ-028 After rst deasserts, the first clock edge with start=1 SHALL begin a normal operation.

Verification
REQ-029 a=0x35, b=0x12, start at E0 -> at E8: done=1, diff=0x23, borrow=0, zero=0, neg=0, ovf=0; done=0 at E9.
REQ-030 a=0x10, b=0x20 -> diff=0xF0, borrow=1, neg=1, ovf=0, zero=0.
REQ-031 a=0x80, b=0x01 -> diff=0x7F, ovf=1, borrow=0, neg=0; and a=0x7F, b=0xFF -> diff=0x80, ovf=1, borrow=1.
REQ-032 a=0x5A, b=0x5A -> diff=0x00, zero=1, borrow=0, neg=0, ovf=0.
REQ-033 Reset and start-ignore checks:
- start pulsed at E3 during RUN with new operands -> ignored; first result is still unchanged at E8.
- rst asserted between E3 and E4 -> all outputs 0 immediately, with no done.
- next start produces a correct result 8 edges later.
REQ-034 start held high with a/b stepping through 16 random pairs -> one done every 10 cycles, and every diff/flag set matches the reference model (a - b) mod 256.
